// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the per-operation control word captured at start.
package muldiv_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MULT  = 3'b000;
    localparam md_op_t MD_MULTU = 3'b001;
    localparam md_op_t MD_DIV   = 3'b010;
    localparam md_op_t MD_DIVU  = 3'b011;
    localparam md_op_t MD_MTHI  = 3'b100;
    localparam md_op_t MD_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // neg_res negates the product or quotient; neg_rem negates the remainder.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
    } md_ctl_t;

    function automatic logic is_iterative(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_move(input md_op_t op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle of the multiply/divide unit.
interface muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data1, data2, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator: shift-add for multiply,
// restoring trial-subtract and shift for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_trial;

    // Multiply: acc = {partial product, remaining multiplier bits}; the
    // carry out of the add is shifted back into the top of the accumulator.
    assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);

    // Divide: acc = {partial remainder, unconsumed dividend / quotient bits}.
    assign w_rem_shift = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial     = w_rem_shift - {1'b0, i_operand};

    always_comb begin
        o_acc = i_acc;
        if (i_is_div) begin
            if (!w_trial[WIDTH]) begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Mul/div run WIDTH iterations on operand magnitudes, then sign-fix in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    md_ctl_t            r_ctl;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_neg1;
    logic               w_neg2;
    logic               w_zero1;
    logic               w_zero2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_start_md;
    logic               w_start_mv;
    md_ctl_t            w_ctl;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign w_is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    assign w_neg1   = w_signed & bus.data1[WIDTH-1];
    assign w_neg2   = w_signed & bus.data2[WIDTH-1];
    assign w_zero1  = (bus.data1 == '0);
    assign w_zero2  = (bus.data2 == '0);
    assign w_mag1   = w_neg1 ? (~bus.data1 + 1'b1) : bus.data1;
    assign w_mag2   = w_neg2 ? (~bus.data2 + 1'b1) : bus.data2;

    // A flush in the same cycle kills any start, including HI/LO moves.
    assign w_start_md = bus.start & ~bus.flush & is_iterative(bus.op);
    assign w_start_mv = bus.start & ~bus.flush & is_move(bus.op);

    // Divide by zero keeps the all-ones quotient unsigned; the remainder
    // negation then restores the raw dividend into HI.
    always_comb begin
        w_ctl.is_div  = w_is_div;
        w_ctl.neg_rem = w_is_div & w_neg1;
        if (w_is_div) begin
            w_ctl.neg_res = (w_neg1 ^ w_neg2) & ~w_zero2;
        end else begin
            w_ctl.neg_res = (w_neg1 ^ w_neg2) & ~w_zero1 & ~w_zero2;
        end
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_is_div  (r_ctl.is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    assign w_prod = r_ctl.neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_ctl.neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_ctl.neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        if (r_ctl.is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_ctl     <= '0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_md) begin
                        r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        r_operand <= w_is_div ? w_mag2 : w_mag1;
                        r_ctl     <= w_ctl;
                        r_count   <= '0;
                        r_state   <= ST_RUN;
                    end else if (w_start_mv) begin
                        if (bus.op == MD_MTHI) begin
                            r_hi <= bus.data1;
                        end else begin
                            r_lo <= bus.data1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc   <= w_step_acc;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_ITER) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!bus.flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the sequential successor to the single-cycle ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the execute stage. Multiply and divide operations are radix-2 and run for WIDTH+2 cycles; the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand width and width of each of HI and LO.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation code (package constants).
- `data1`  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
- `data2`  in  WIDTH  rt operand (multiplier/divisor).
- `flush`  in  1  abort the in-flight operation (exception/branch kill).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE, `start`=1, op is MULT/MULTU/DIV/DIVU:**
  - Latch operand magnitudes (signed ops take absolute values; unsigned ops take them raw).
  - Latch result signs and the op; clear the iteration counter.
  - Go to RUN.
- **IDLE, `start`=1, op is MTHI/MTLO:** write `data1` to `hi`/`lo` at that edge. Stay in IDLE; no `busy`, no `done`.
- **Undefined op codes (110, 111):** `start` is ignored.
- **RUN:**
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Exactly WIDTH iterations, then go to FIX.
- **FIX:**
  - Apply sign correction.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Multiply results: 2·WIDTH-bit product; `hi` takes the upper half, `lo` the lower half.
  - Signed product is negative iff the operand signs differ and neither operand is 0.
- Divide results: `lo` = quotient, `hi` = remainder.
  - Truncating division: the quotient rounds toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): `lo` = all ones, `hi` = `data1` as captured. Latency is unchanged.
- Signed MIN / -1: `lo` = MIN, `hi` = 0 (two's-complement wrap). No exception.
- **`start` while `busy`:** ignored, including MTHI/MTLO. Upstream stalls on `busy`.
- **`flush`:**
  - In RUN or FIX: return to IDLE at the next edge. `hi`/`lo` keep their prior values; no `done`.
  - `flush` together with `start` in IDLE: flush wins, and the start is dropped.
- Operand inputs are don't-care after the start edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset mid-operation aborts immediately and asynchronously. The operation is lost.
- Start accepted at edge E0. `busy`=1 from after E0 until after E(WIDTH+1).
- RUN iterates at edges E1..E(WIDTH). FIX commits at edge E(WIDTH+1).
- After E(WIDTH+1): `hi`/`lo` hold the new value and `done`=1 for one cycle, with `busy`=0 in that same cycle.
- Back-to-back: a new `start` may be accepted at edge E(WIDTH+2), the cycle `done` is high. Total throughput is WIDTH+2 cycles per operation.
- MTHI/MTLO take effect at the sampling edge, so there is zero latency for readers in the next cycle.
- `hi`/`lo` change only on a FIX commit, an MTHI/MTLO write or reset.

## Structure
- Shared package `muldiv_pkg`:
  - Op constants: MD_MULT=000, MD_MULTU=001, MD_DIV=010, MD_DIVU=011, MD_MTHI=100, MD_MTLO=101.
  - State encoding: IDLE, RUN, FIX.
- One sub-module, `muldiv_step`: the combinational single-iteration datapath.
  - Add/shift for multiply, or trial-subtract/shift for divide, on the 2·WIDTH-bit accumulator.
  - The FSM, counter, sign capture and HI/LO registers stay in `muldiv_unit`.
- Counter width is clog2(WIDTH+1).

## Test plan
- **Signed multiply:** MULT 0xFFFFFFFD × 0x00000005 → after 34 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, single `done` pulse. Then MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed divide:** DIV 0xFFFFFFF9 (-7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIVU 7/2 → `lo`=3, `hi`=1.
- **Divide corner cases:** DIVU 7/0 → `lo`=0xFFFFFFFF, `hi`=7. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Flush:** MTHI 0x1234 then MTLO 0x5678 → `hi`/`lo` update the next cycle, `busy` stays 0. Then MULT, with `flush` asserted 10 cycles after start → `busy` drops the next cycle, no `done`, `hi`=0x1234, `lo`=0x5678.
- **Start while busy:** during a DIVU, pulse `start` with MTLO 0xAAAA and with MULT → both ignored; only the DIVU result is committed. A new MULT issued in the `done` cycle is accepted.
- **Reset mid-operation:** assert `rst` mid-DIV → `busy`, `done`, `hi`, `lo` go to 0 asynchronously. After deassertion, a MULT 2×3 completes with `lo`=6, `hi`=0.
